// File: rtl/arctan2_arbiter_if.sv
// Request, core-side and result signals shared between the arbiter and its neighbours.
interface arctan2_arbiter_if #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 16,
  parameter int N_CH       = 4
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH*DIN_WIDTH-1:0] req_x;
  logic [N_CH*DIN_WIDTH-1:0] req_y;
  logic [N_CH-1:0]           req_valid;
  logic [N_CH-1:0]           req_ready;
  logic [DIN_WIDTH-1:0]      core_x;
  logic [DIN_WIDTH-1:0]      core_y;
  logic                      core_valid;
  logic                      core_ready;
  logic [DOUT_WIDTH-1:0]     core_dout;
  logic                      core_dout_valid;
  logic [DOUT_WIDTH-1:0]     dout;
  logic [CW-1:0]             dout_ch;
  logic                      dout_valid;
  logic                      tag_err;

  modport slave (
    input  req_x, req_y, req_valid, core_ready, core_dout, core_dout_valid,
    output req_ready, core_x, core_y, core_valid, dout, dout_ch, dout_valid, tag_err
  );

  modport master (
    output req_x, req_y, req_valid, core_ready, core_dout, core_dout_valid,
    input  req_ready, core_x, core_y, core_valid, dout, dout_ch, dout_valid, tag_err
  );
endinterface

// File: rtl/arctan2_arbiter.sv
// Round-robin sharing of one in-order arctan2 core among N_CH requesters;
// an in-order tag FIFO returns each core result with its originating channel.
module arctan2_arbiter #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 16,
  parameter int N_CH       = 4,
  parameter int TAG_DEPTH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  arctan2_arbiter_if.slave io_bus
);
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int N_TAG = 2 ** TAG_DEPTH;
  localparam logic [TAG_DEPTH:0]   CNT_FULL = (TAG_DEPTH + 1)'(N_TAG);
  localparam logic [TAG_DEPTH:0]   CNT_ONE  = (TAG_DEPTH + 1)'(1);
  localparam logic [TAG_DEPTH-1:0] PTR_ONE  = TAG_DEPTH'(1);

  typedef enum logic {ARB, ISSUE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_ptr;
  logic [DIN_WIDTH-1:0]  r_core_x;
  logic [DIN_WIDTH-1:0]  r_core_y;
  logic                  r_core_valid;
  logic [DOUT_WIDTH-1:0] r_dout;
  logic [CW-1:0]         r_dout_ch;
  logic                  r_dout_valid;
  logic                  r_tag_err;
  logic [CW-1:0]         r_tag_mem [N_TAG];
  logic [TAG_DEPTH-1:0]  r_wr_ptr;
  logic [TAG_DEPTH-1:0]  r_rd_ptr;
  logic [TAG_DEPTH:0]    r_count;

  logic [DIN_WIDTH-1:0]  w_req_x [N_CH];
  logic [DIN_WIDTH-1:0]  w_req_y [N_CH];
  logic [N_CH-1:0]       w_req_ready;
  logic [CW:0]           w_idx;
  logic [CW-1:0]         w_win;
  logic [CW-1:0]         w_ptr_next;
  logic                  w_any;
  logic                  w_full;
  logic                  w_grant;
  logic                  w_pop;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign w_req_x[gi] = io_bus.req_x[gi*DIN_WIDTH +: DIN_WIDTH];
      assign w_req_y[gi] = io_bus.req_y[gi*DIN_WIDTH +: DIN_WIDTH];
    end
  endgenerate

  // First valid channel at or after the pointer, wrapping modulo N_CH.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_idx = {1'b0, r_ptr} + (CW + 1)'(k);
      if (w_idx >= (CW + 1)'(N_CH)) begin
        w_idx = w_idx - (CW + 1)'(N_CH);
      end
      if (!w_any && io_bus.req_valid[w_idx[CW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[CW-1:0];
      end
    end
  end

  assign w_full     = (r_count == CNT_FULL);
  assign w_grant    = (r_state == ARB) && !rst && io_bus.core_ready && !w_full && w_any;
  assign w_pop      = io_bus.core_dout_valid && (r_count != '0);
  assign w_ptr_next = (w_win == CW'(N_CH - 1)) ? '0 : w_win + CW'(1);

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = '0;
    case (r_state)
      ARB: begin
        if (w_grant) begin
          w_state_next       = ISSUE;
          w_req_ready[w_win] = 1'b1;
        end
      end
      ISSUE:   w_state_next = ARB;
      default: w_state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB;
      r_ptr        <= '0;
      r_core_x     <= '0;
      r_core_y     <= '0;
      r_core_valid <= 1'b0;
      r_dout       <= '0;
      r_dout_ch    <= '0;
      r_dout_valid <= 1'b0;
      r_tag_err    <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_core_valid <= w_grant;
      r_dout_valid <= w_pop;
      if (w_grant) begin
        r_core_x <= w_req_x[w_win];
        r_core_y <= w_req_y[w_win];
        r_ptr    <= w_ptr_next;
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_dout    <= io_bus.core_dout;
        r_dout_ch <= r_tag_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
      end
      if (w_grant && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_grant && w_pop) begin
        r_count <= r_count - CNT_ONE;
      end
      // A result with no outstanding tag cannot be attributed; drop it and flag.
      if (io_bus.core_dout_valid && (r_count == '0)) begin
        r_tag_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_tag_mem[r_wr_ptr] <= w_win;
    end
  end

  assign io_bus.req_ready  = w_req_ready;
  assign io_bus.core_x     = r_core_x;
  assign io_bus.core_y     = r_core_y;
  assign io_bus.core_valid = r_core_valid;
  assign io_bus.dout       = r_dout;
  assign io_bus.dout_ch    = r_dout_ch;
  assign io_bus.dout_valid = r_dout_valid;
  assign io_bus.tag_err    = r_tag_err;
endmodule
